// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by an internal FIFO; queued words are sent back-to-back on tx.
// Defining UART_TX_PARITY_EN adds a parity bit after the data bits.
module uart_tx_fifo #(
    parameter int CLK_HZ     = 25000000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                            clk_25mhz,
    input  logic                            resetn,
    input  logic [DATA_BITS-1:0]            data,
    input  logic                            wr_en,
    input  logic                            parity_odd,
    output logic                            full,
    output logic                            empty,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
    output logic                            overflow,
    output logic                            busy,
    output logic                            tx
);
    localparam int DIV = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int CW  = $clog2(FIFO_DEPTH + 1);
    localparam int DW  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int BW  = $clog2(DATA_BITS);
`ifdef UART_TX_PARITY_EN
    localparam int EW  = DATA_BITS + 1;
`else
    localparam int EW  = DATA_BITS;
`endif

    generate
        if (DIV < 2) begin : g_bad_div
            $error("uart_tx_fifo: baud divisor must be at least 2");
        end
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
            $error("uart_tx_fifo: DATA_BITS must be 5..9");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
            $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
        end
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("uart_tx_fifo: FIFO_DEPTH must be a power of 2, at least 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t               state;
    logic [EW-1:0]        mem [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic [EW-1:0]        wr_entry;
    logic [EW-1:0]        head;
    logic [DATA_BITS-1:0] shreg;
    logic [DW-1:0]        baud_cnt;
    logic [BW-1:0]        bit_cnt;
    logic                 stop_cnt;
    logic                 baud_done;
    logic                 pop;
    logic                 wr_accept;
`ifdef UART_TX_PARITY_EN
    logic                 par_bit;

    // Each entry carries its own parity sense so consecutive words can differ.
    assign wr_entry = {parity_odd, data};
`else
    logic                 unused_parity_odd;

    assign wr_entry          = data;
    assign unused_parity_odd = parity_odd;
`endif

    assign head      = mem[rd_ptr];
    assign empty     = (fifo_count == '0);
    assign full      = (fifo_count == CW'(FIFO_DEPTH));
    assign busy      = (state != IDLE) || !empty;
    assign baud_done = (baud_cnt == DW'(DIV - 1));
    assign pop       = !empty && ((state == IDLE) ||
                       (state == STOP && baud_done && stop_cnt == 1'(STOP_BITS - 1)));
    assign wr_accept = wr_en && (!full || pop);

    always_ff @(posedge clk_25mhz) begin
        if (wr_accept) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    always_ff @(posedge clk_25mhz or negedge resetn) begin
        if (!resetn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (wr_accept && !pop) begin
                fifo_count <= fifo_count + CW'(1);
            end else if (pop && !wr_accept) begin
                fifo_count <= fifo_count - CW'(1);
            end
            if (wr_en && !wr_accept) begin
                overflow <= 1'b1;
            end
        end
    end

    // A pop only happens from IDLE or at the end of the last stop bit, so it
    // is handled ahead of the per-state logic and always starts a new frame.
    always_ff @(posedge clk_25mhz or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            tx       <= 1'b1;
            shreg    <= '0;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_bit  <= 1'b0;
`endif
        end else if (pop) begin
            state    <= START;
            tx       <= 1'b0;
            shreg    <= head[DATA_BITS-1:0];
            baud_cnt <= '0;
`ifdef UART_TX_PARITY_EN
            par_bit  <= ^head;
`endif
        end else begin
            case (state)
                IDLE: begin
                    tx       <= 1'b1;
                    baud_cnt <= '0;
                end
                START: begin
                    if (baud_done) begin
                        state    <= DATA;
                        tx       <= shreg[0];
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                    end else begin
                        baud_cnt <= baud_cnt + DW'(1);
                    end
                end
                DATA: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        if (bit_cnt == BW'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                            state    <= PARITY;
                            tx       <= par_bit;
`else
                            state    <= STOP;
                            tx       <= 1'b1;
                            stop_cnt <= 1'b0;
`endif
                        end else begin
                            shreg   <= shreg >> 1;
                            tx      <= shreg[1];
                            bit_cnt <= bit_cnt + BW'(1);
                        end
                    end else begin
                        baud_cnt <= baud_cnt + DW'(1);
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (baud_done) begin
                        state    <= STOP;
                        tx       <= 1'b1;
                        baud_cnt <= '0;
                        stop_cnt <= 1'b0;
                    end else begin
                        baud_cnt <= baud_cnt + DW'(1);
                    end
                end
`endif
                STOP: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        if (stop_cnt == 1'(STOP_BITS - 1)) begin
                            state <= IDLE;
                            tx    <= 1'b1;
                        end else begin
                            stop_cnt <= stop_cnt + 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + DW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: three instances (8N1/16, 8N1/4-deep, 7 data + 2 stop) at DIV = 10,
// checked by a per-bit line decoder against a queue of expected words.
module tb_uart_tx_fifo;
`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FL_M = 10 * (1 + 8 + PAR + 1);

    bit   clk = 1'b0;
    logic resetn = 1'b0;
    logic parity_odd = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    logic [7:0] data_m = '0;
    logic       wr_m = 1'b0;
    logic       full_m, empty_m, overflow_m, busy_m, tx_m;
    logic [4:0] count_m;

    logic [7:0] data_s = '0;
    logic       wr_s = 1'b0;
    logic       full_s, empty_s, overflow_s, busy_s, tx_s;
    logic [2:0] count_s;

    logic [6:0] data_f = '0;
    logic       wr_f = 1'b0;
    logic       full_f, empty_f, overflow_f, busy_f, tx_f;
    logic [4:0] count_f;

    logic [8:0] exp_m[$];
    logic [8:0] exp_s[$];
    logic [8:0] exp_f[$];
    logic       exp_par[$];

    always #20 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_fifo #(.CLK_HZ(25000000), .BAUD(2500000), .DATA_BITS(8), .STOP_BITS(1), .FIFO_DEPTH(16)) u_main (
        .clk_25mhz(clk), .resetn(resetn), .data(data_m), .wr_en(wr_m), .parity_odd(parity_odd),
        .full(full_m), .empty(empty_m), .fifo_count(count_m), .overflow(overflow_m), .busy(busy_m), .tx(tx_m));

    uart_tx_fifo #(.CLK_HZ(25000000), .BAUD(2500000), .DATA_BITS(8), .STOP_BITS(1), .FIFO_DEPTH(4)) u_small (
        .clk_25mhz(clk), .resetn(resetn), .data(data_s), .wr_en(wr_s), .parity_odd(parity_odd),
        .full(full_s), .empty(empty_s), .fifo_count(count_s), .overflow(overflow_s), .busy(busy_s), .tx(tx_s));

    uart_tx_fifo #(.CLK_HZ(25000000), .BAUD(2500000), .DATA_BITS(7), .STOP_BITS(2), .FIFO_DEPTH(16)) u_fmt (
        .clk_25mhz(clk), .resetn(resetn), .data(data_f), .wr_en(wr_f), .parity_odd(parity_odd),
        .full(full_f), .empty(empty_f), .fifo_count(count_f), .overflow(overflow_f), .busy(busy_f), .tx(tx_f));

    function automatic logic tx_of(input int sel);
        case (sel)
            0:       return tx_m;
            1:       return tx_s;
            default: return tx_f;
        endcase
    endfunction

    task automatic drive_wr(input int sel, input logic en, input logic [8:0] w);
        case (sel)
            0:       begin wr_m = en; data_m = w[7:0]; end
            1:       begin wr_s = en; data_s = w[7:0]; end
            default: begin wr_f = en; data_f = w[6:0]; end
        endcase
    endtask

    // Called on a negedge; the write is taken by the following posedge.
    task automatic push_word(input int sel, input logic [8:0] w, input logic odd);
        parity_odd = odd;
        drive_wr(sel, 1'b1, w);
        @(negedge clk);
        drive_wr(sel, 1'b0, w);
    endtask

    // Decodes one frame sampling every negedge; any sample differing from its bit's
    // mid-sample, a high start bit or a low stop bit counts as a bad sample.
    task automatic rx_frame(input int sel, input int nbits, input int nstop,
                            output logic [8:0] word, output logic pbit,
                            output int bad_samples, output int start_cyc, output bit timeout);
        int         waited;
        int         nb;
        logic [9:0] smp;
        logic       mid;
        word = '0;
        pbit = 1'b0;
        bad_samples = 0;
        start_cyc = 0;
        timeout = 1'b0;
        waited = 0;
        @(negedge clk);
        while (tx_of(sel) !== 1'b0 && waited < 3000) begin
            @(negedge clk);
            waited++;
        end
        if (tx_of(sel) !== 1'b0) begin
            timeout = 1'b1;
            return;
        end
        start_cyc = cyc;
        nb = 1 + nbits + PAR + nstop;
        for (int b = 0; b < nb; b++) begin
            for (int k = 0; k < 10; k++) begin
                if (b != 0 || k != 0) @(negedge clk);
                smp[k] = tx_of(sel);
            end
            mid = smp[5];
            for (int k = 0; k < 10; k++) begin
                if (smp[k] !== mid) bad_samples++;
            end
            if (b == 0) begin
                if (mid !== 1'b0) bad_samples++;
            end else if (b <= nbits) begin
                word[b-1] = mid;
            end else if (PAR == 1 && b == nbits + 1) begin
                pbit = mid;
            end else if (mid !== 1'b1) begin
                bad_samples++;
            end
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (tx_m !== 1'b1) begin bad++; $display("[TB] FAIL reset_tx got=%b want=1", tx_m); end
        total++; if (busy_m !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b want=0", busy_m); end
        total++; if (empty_m !== 1'b1 || full_m !== 1'b0) begin bad++; $display("[TB] FAIL reset_flags got empty=%b full=%b want empty=1 full=0", empty_m, full_m); end
        total++; if (count_m !== 5'd0) begin bad++; $display("[TB] FAIL reset_count got=%0d want=0", count_m); end
        total++; if (overflow_m !== 1'b0 || overflow_s !== 1'b0) begin bad++; $display("[TB] FAIL reset_overflow got=%b/%b want=0/0", overflow_m, overflow_s); end
        resetn = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single();
        logic [8:0] w, e;
        logic       p;
        int         bs, sc, wc;
        bit         to;
        exp_m.push_back(9'h0A5);
        fork
            begin
                push_word(0, 9'h0A5, 1'b0);
                wc = cyc;
                total++; if (count_m !== 5'd1 || empty_m !== 1'b0) begin bad++; $display("[TB] FAIL single_count got count=%0d empty=%b want count=1 empty=0", count_m, empty_m); end
            end
            rx_frame(0, 8, 1, w, p, bs, sc, to);
        join
        e = exp_m.pop_front();
        total++; if (to !== 1'b0) begin bad++; $display("[TB] FAIL single_timeout got=timeout want=frame"); end
        total++; if (w !== e) begin bad++; $display("[TB] FAIL single_data got=%h want=%h", w, e); end
        total++; if (bs !== 0) begin bad++; $display("[TB] FAIL single_shape got=%0d bad samples want=0", bs); end
        total++; if (sc - wc !== 1) begin bad++; $display("[TB] FAIL single_latency got=%0d want=1", sc - wc); end
        total++; if (busy_m !== 1'b1) begin bad++; $display("[TB] FAIL single_busy_hold got=%b want=1", busy_m); end
        @(negedge clk);
        total++; if (busy_m !== 1'b0) begin bad++; $display("[TB] FAIL single_busy_fall got=%b want=0", busy_m); end
    endtask

    task automatic test_back_to_back();
        logic [8:0] w, e;
        logic [8:0] words [4];
        logic       p;
        int         bs, sc, prev_sc, peak;
        bit         to;
        words[0] = 9'h000; words[1] = 9'h0FF; words[2] = 9'h055; words[3] = 9'h00F;
        peak = 0;
        for (int i = 0; i < 4; i++) exp_m.push_back(words[i]);
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    push_word(0, words[i], 1'b0);
                    if (int'(count_m) > peak) peak = int'(count_m);
                end
            end
            begin
                prev_sc = 0;
                for (int i = 0; i < 4; i++) begin
                    rx_frame(0, 8, 1, w, p, bs, sc, to);
                    e = exp_m.pop_front();
                    total++; if (to !== 1'b0 || w !== e || bs !== 0) begin bad++; $display("[TB] FAIL burst_frame%0d got=%h bad=%0d to=%0d want=%h bad=0 to=0", i, w, bs, to, e); end
                    if (i > 0) begin
                        total++; if (sc - prev_sc !== FL_M) begin bad++; $display("[TB] FAIL burst_gap%0d got=%0d want=%0d", i, sc - prev_sc, FL_M); end
                    end
                    prev_sc = sc;
                end
            end
        join
        total++; if (peak !== 3) begin bad++; $display("[TB] FAIL burst_peak got=%0d want=3", peak); end
        @(negedge clk);
        total++; if (busy_m !== 1'b0 || empty_m !== 1'b1) begin bad++; $display("[TB] FAIL burst_end got busy=%b empty=%b want busy=0 empty=1", busy_m, empty_m); end
    endtask

    task automatic test_overflow();
        logic [8:0] w, e;
        logic       p;
        int         bs, sc;
        bit         to;
        fork
            begin
                for (int i = 1; i <= 6; i++) begin
                    if (i <= 5) exp_s.push_back(9'(i * 17));
                    push_word(1, 9'(i * 17), 1'b0);
                end
                total++; if (full_s !== 1'b1 || count_s !== 3'd4) begin bad++; $display("[TB] FAIL ovf_full got full=%b count=%0d want full=1 count=4", full_s, count_s); end
                total++; if (overflow_s !== 1'b1) begin bad++; $display("[TB] FAIL ovf_flag got=%b want=1", overflow_s); end
            end
            begin
                for (int i = 0; i < 5; i++) begin
                    rx_frame(1, 8, 1, w, p, bs, sc, to);
                    e = exp_s.pop_front();
                    total++; if (to !== 1'b0 || w !== e || bs !== 0) begin bad++; $display("[TB] FAIL ovf_frame%0d got=%h bad=%0d to=%0d want=%h", i, w, bs, to, e); end
                end
            end
        join
        rx_frame(1, 8, 1, w, p, bs, sc, to);
        total++; if (to !== 1'b1) begin bad++; $display("[TB] FAIL ovf_extra_frame got=frame %h want=none", w); end
        total++; if (overflow_s !== 1'b1 || empty_s !== 1'b1) begin bad++; $display("[TB] FAIL ovf_sticky got ovf=%b empty=%b want ovf=1 empty=1", overflow_s, empty_s); end
    endtask

    task automatic test_format();
        logic [8:0] w, e;
        logic       p;
        int         bs, sc, wc;
        bit         to;
        exp_f.push_back(9'h041);
        fork
            begin
                push_word(2, 9'h041, 1'b0);
                wc = cyc;
            end
            rx_frame(2, 7, 2, w, p, bs, sc, to);
        join
        e = exp_f.pop_front();
        total++; if (to !== 1'b0 || w !== e) begin bad++; $display("[TB] FAIL fmt_data got=%h to=%0d want=%h", w, to, e); end
        total++; if (bs !== 0 || sc - wc !== 1) begin bad++; $display("[TB] FAIL fmt_shape got bad=%0d lat=%0d want bad=0 lat=1", bs, sc - wc); end
        total++; if (busy_f !== 1'b1) begin bad++; $display("[TB] FAIL fmt_busy_hold got=%b want=1", busy_f); end
        @(negedge clk);
        total++; if (busy_f !== 1'b0) begin bad++; $display("[TB] FAIL fmt_busy_fall got=%b want=0", busy_f); end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        logic [8:0] w, e;
        logic       p, ep;
        int         bs, sc, prev_sc;
        bit         to;
        exp_m.push_back(9'h007); exp_par.push_back(^8'h07 ^ 1'b0);
        exp_m.push_back(9'h007); exp_par.push_back(^8'h07 ^ 1'b1);
        fork
            begin
                push_word(0, 9'h007, 1'b0);
                push_word(0, 9'h007, 1'b1);
            end
            begin
                prev_sc = 0;
                for (int i = 0; i < 2; i++) begin
                    rx_frame(0, 8, 1, w, p, bs, sc, to);
                    e = exp_m.pop_front();
                    ep = exp_par.pop_front();
                    total++; if (to !== 1'b0 || w !== e || bs !== 0) begin bad++; $display("[TB] FAIL par_frame%0d got=%h bad=%0d want=%h", i, w, bs, e); end
                    total++; if (p !== ep) begin bad++; $display("[TB] FAIL par_bit%0d got=%b want=%b", i, p, ep); end
                    if (i == 1) begin
                        total++; if (sc - prev_sc !== 110) begin bad++; $display("[TB] FAIL par_len got=%0d want=110", sc - prev_sc); end
                    end
                    prev_sc = sc;
                end
            end
        join
        parity_odd = 1'b0;
        repeat (2) @(negedge clk);
    endtask
`endif

    task automatic test_reset_mid_frame();
        logic [8:0] w, e;
        logic       p;
        int         bs, sc, lows;
        bit         to;
        push_word(0, 9'h000, 1'b0);
        push_word(0, 9'h081, 1'b0);
        push_word(0, 9'h07E, 1'b0);
        repeat (33) @(negedge clk);
        total++; if (tx_m !== 1'b0 || busy_m !== 1'b1) begin bad++; $display("[TB] FAIL rst_pre got tx=%b busy=%b want tx=0 busy=1", tx_m, busy_m); end
        resetn = 1'b0;
        #1;
        total++; if (tx_m !== 1'b1 || busy_m !== 1'b0) begin bad++; $display("[TB] FAIL rst_async got tx=%b busy=%b want tx=1 busy=0", tx_m, busy_m); end
        total++; if (count_m !== 5'd0 || empty_m !== 1'b1) begin bad++; $display("[TB] FAIL rst_fifo got count=%0d empty=%b want count=0 empty=1", count_m, empty_m); end
        exp_m.delete();
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        lows = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (tx_m !== 1'b1 || busy_m !== 1'b0) lows++;
        end
        total++; if (lows !== 0) begin bad++; $display("[TB] FAIL rst_idle got=%0d active cycles want=0", lows); end
        exp_m.push_back(9'h03C);
        fork
            push_word(0, 9'h03C, 1'b0);
            rx_frame(0, 8, 1, w, p, bs, sc, to);
        join
        e = exp_m.pop_front();
        total++; if (to !== 1'b0 || w !== e || bs !== 0) begin bad++; $display("[TB] FAIL rst_after got=%h bad=%0d to=%0d want=%h", w, bs, to, e); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_format();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
